// File: rtl/bram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_if
// Bundles the BRAM initiator port and the outgoing valid/ready stream of
// bram_stream_reader. Signal names carry the reader's direction suffixes.
//   mem_req_o / mem_addr_o / mem_wdata_o / mem_bwe_o : reader -> BRAM
//   mem_rdata_i                                      : BRAM -> reader
//   m_valid_o / m_data_o / m_last_o                  : reader -> consumer
//   m_ready_i                                        : consumer -> reader
// Modports: master = reader side, slave = BRAM/consumer side.
// ---------------------------------------------------------------------------
interface bram_stream_reader_if #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1024
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int DW = NB_COL * COL_WIDTH;

    logic              mem_req_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [NB_COL-1:0] mem_bwe_o;
    logic [DW-1:0]     mem_rdata_i;
    logic              m_valid_o;
    logic [DW-1:0]     m_data_o;
    logic              m_last_o;
    logic              m_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_bwe_o,
        input  mem_rdata_i,
        output m_valid_o, m_data_o, m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_bwe_o,
        output mem_rdata_i,
        input  m_valid_o, m_data_o, m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Reads len_i consecutive BRAM words starting at base_addr_i (address wraps
// RAM_DEPTH-1 -> 0) and streams them out with a last flag. Never writes.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   start_i          start pulse, sampled in IDLE only
//   base_addr_i      first word address
//   len_i            word count 0..RAM_DEPTH (0 gives an immediate done)
//   busy_o           high from accepted start until done
//   done_o           one-cycle completion pulse
//   bus              bram_stream_reader_if.master (BRAM port + stream)
//   chksum_o         XOR of all handshaked words (BRAM_READER_CHKSUM_EN only)
// Optional feature macro: BRAM_READER_CHKSUM_EN
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [$clog2(RAM_DEPTH)-1:0] base_addr_i,
    input  logic [$clog2(RAM_DEPTH):0]   len_i,
    output logic                         busy_o,
    output logic                         done_o,
`ifdef BRAM_READER_CHKSUM_EN
    output logic [NB_COL*COL_WIDTH-1:0]  chksum_o,
`endif
    bram_stream_reader_if.master         bus
);
    localparam int AW        = $clog2(RAM_DEPTH);
    localparam int DataWidth = NB_COL * COL_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW:0]          issue_rem_q, issue_rem_d;
    logic [AW:0]          push_rem_q, push_rem_d;
    logic                 inflight_q;
    logic                 done_q, done_d;
    logic [DataWidth-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                 last0_q, last0_d, last1_q, last1_d;
    logic [1:0]           cnt_q, cnt_d;

    logic                 pop, push, push_last, issue, start_acc;
    logic [2:0]           occ;
    logic [AW-1:0]        addr_inc;

    assign pop       = (cnt_q != 2'd0) && bus.m_ready_i;
    assign push      = inflight_q;
    assign push_last = (push_rem_q == (AW+1)'(1));
    // Words buffered or in flight after this cycle's pop; a new read is
    // issued only if its data is guaranteed a FIFO slot when it returns.
    assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (issue_rem_q != '0) && (occ < 3'd2);
    assign addr_inc  = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);

    // Control FSM and issue/emit counters
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        push_rem_d  = push_rem_q;
        done_d      = 1'b0;
        start_acc   = 1'b0;
        if (push) begin
            push_rem_d = push_rem_q - (AW+1)'(1);
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        addr_d      = base_addr_i;
                        issue_rem_d = len_i;
                        push_rem_d  = len_i;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_inc;
                    issue_rem_d = issue_rem_q - (AW+1)'(1);
                    if (issue_rem_q == (AW+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last0_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry output FIFO; entry 0 is the head driving the stream
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data0_d = bus.mem_rdata_i;
                    last0_d = push_last;
                end else begin
                    data1_d = bus.mem_rdata_i;
                    last1_d = push_last;
                end
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    data0_d = bus.mem_rdata_i;
                    last0_d = push_last;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = bus.mem_rdata_i;
                    last1_d = push_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            push_rem_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            push_rem_q  <= push_rem_d;
            inflight_q  <= issue;
            done_q      <= done_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && !pop && (cnt_q == 2'd2)));
        end
    end

`ifdef BRAM_READER_CHKSUM_EN
    logic [DataWidth-1:0] chk_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_q <= '0;
        end else if (start_acc) begin
            chk_q <= '0;
        end else if (pop) begin
            chk_q <= chk_q ^ data0_q;
        end
    end

    assign chksum_o = chk_q;
`endif

    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign bus.mem_req_o   = issue;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = '0;
    assign bus.mem_bwe_o   = '0;
    assign bus.m_valid_o   = (cnt_q != 2'd0);
    assign bus.m_data_o    = data0_q;
    assign bus.m_last_o    = last0_q;
endmodule
